// File: rtl/tic_tac_toe_nxn_if.sv
// Request/position inputs and board/result outputs of the tic-tac-toe engine.
// The master drives the requests and the slave (the engine) drives the board and results.
interface tic_tac_toe_nxn_if #(
    parameter int N = 3
) ();
    localparam int CELLS = N * N;
    localparam int PW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);

    logic                 play;
    logic                 pc;
    logic [PW-1:0]        player_position;
    logic [PW-1:0]        computer_position;
    logic [2*CELLS-1:0]   board;
    logic [1:0]           who;
    logic                 turn;
    logic                 illegal;
    logic [CW-1:0]        move_count;

    modport master (
        output play, pc, player_position, computer_position,
        input  board, who, turn, illegal, move_count
    );

    modport slave (
        input  play, pc, player_position, computer_position,
        output board, who, turn, illegal, move_count
    );
endinterface

// File: rtl/tic_tac_toe_nxn.sv
// NxN tic-tac-toe referee: accepts edge-triggered moves from two sides, then
// spends one CHECK cycle scoring the mover for a WIN_LEN line or a full-board draw.
module tic_tac_toe_nxn #(
    parameter int N       = 3,
    parameter int WIN_LEN = 3,
    parameter int FIRST   = 0
) (
    input  logic               clk,
    input  logic               reset,
    tic_tac_toe_nxn_if.slave   bus
);
    localparam int CELLS = N * N;
    localparam int PW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);
    localparam logic [PW:0] CELLS_V = (PW + 1)'(CELLS);

    typedef enum logic [1:0] {
        S_TURN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*CELLS-1:0]   board_q, board_d;
    logic [1:0]           who_q, who_d;
    logic                 turn_q, turn_d;
    logic                 illegal_q, illegal_d;
    logic [CW-1:0]        move_count_q, move_count_d;
    logic                 play_q, play_d;
    logic                 pc_q, pc_d;

    logic [1:0]           cell_mark [CELLS];
    logic [CELLS-1:0]     cell_empty;
    logic [2**PW-1:0]     empty_pad;
    logic [1:0]           mover_mark;
    logic [CELLS-1:0]     hit_row, hit_col, hit_dia, hit_anti;
    logic                 win;

    assign mover_mark = turn_q ? 2'b10 : 2'b01;

    // Every start cell owns up to four windows; windows that would leave the board tie off to 0.
    genvar gi, gk;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            localparam int R = gi / N;
            localparam int C = gi % N;

            assign cell_mark[gi]  = board_q[2*gi +: 2];
            assign cell_empty[gi] = (cell_mark[gi] == 2'b00);

            if (C + WIN_LEN <= N) begin : g_row
                logic [WIN_LEN-1:0] m;
                for (gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign m[gk] = (cell_mark[gi + gk] == mover_mark);
                end
                assign hit_row[gi] = &m;
            end else begin : g_no_row
                assign hit_row[gi] = 1'b0;
            end

            if (R + WIN_LEN <= N) begin : g_col
                logic [WIN_LEN-1:0] m;
                for (gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign m[gk] = (cell_mark[gi + gk*N] == mover_mark);
                end
                assign hit_col[gi] = &m;
            end else begin : g_no_col
                assign hit_col[gi] = 1'b0;
            end

            if ((R + WIN_LEN <= N) && (C + WIN_LEN <= N)) begin : g_dia
                logic [WIN_LEN-1:0] m;
                for (gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign m[gk] = (cell_mark[gi + gk*(N+1)] == mover_mark);
                end
                assign hit_dia[gi] = &m;
            end else begin : g_no_dia
                assign hit_dia[gi] = 1'b0;
            end

            // Anti-diagonal runs down-left from its start cell.
            if ((R + WIN_LEN <= N) && (C >= WIN_LEN - 1)) begin : g_anti
                logic [WIN_LEN-1:0] m;
                for (gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign m[gk] = (cell_mark[gi + gk*(N-1)] == mover_mark);
                end
                assign hit_anti[gi] = &m;
            end else begin : g_no_anti
                assign hit_anti[gi] = 1'b0;
            end
        end
    endgenerate

    assign win = |{hit_row, hit_col, hit_dia, hit_anti};

    // Pad to the full index range so an out-of-board target reads as occupied.
    always_comb begin
        empty_pad            = '0;
        empty_pad[CELLS-1:0] = cell_empty;
    end

    logic          play_edge, pc_edge, holder_edge, other_edge;
    logic [PW-1:0] tgt;
    logic          move_ok;

    always_comb begin
        play_edge   = bus.play & ~play_q;
        pc_edge     = bus.pc & ~pc_q;
        holder_edge = turn_q ? pc_edge : play_edge;
        other_edge  = turn_q ? play_edge : pc_edge;
        tgt         = turn_q ? bus.computer_position : bus.player_position;
        move_ok     = ({1'b0, tgt} < CELLS_V) && empty_pad[tgt];
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        who_d        = who_q;
        turn_d       = turn_q;
        illegal_d    = 1'b0;
        move_count_d = move_count_q;
        play_d       = bus.play;
        pc_d         = bus.pc;

        unique case (state_q)
            S_TURN: begin
                if (holder_edge) begin
                    if (move_ok) begin
                        for (int i = 0; i < CELLS; i++) begin
                            if (tgt == PW'(i)) begin
                                board_d[2*i +: 2] = mover_mark;
                            end
                        end
                        move_count_d = move_count_q + CW'(1);
                        state_d      = S_CHECK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else if (other_edge) begin
                    illegal_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (win) begin
                    who_d   = mover_mark;
                    state_d = S_DONE;
                end else if (move_count_q == CW'(CELLS)) begin
                    who_d   = 2'b11;
                    state_d = S_DONE;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_TURN;
                end
            end
            S_DONE: begin
                illegal_d = play_edge | pc_edge;
            end
            default: begin
                state_d = S_TURN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_TURN;
            board_q      <= '0;
            who_q        <= 2'b00;
            turn_q       <= 1'(FIRST);
            illegal_q    <= 1'b0;
            move_count_q <= '0;
            play_q       <= bus.play;
            pc_q         <= bus.pc;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            who_q        <= who_d;
            turn_q       <= turn_d;
            illegal_q    <= illegal_d;
            move_count_q <= move_count_d;
            play_q       <= play_d;
            pc_q         <= pc_d;
        end
    end

    assign bus.board      = board_q;
    assign bus.who        = who_q;
    assign bus.turn       = turn_q;
    assign bus.illegal    = illegal_q;
    assign bus.move_count = move_count_q;
endmodule

// File: tb/tb_tic_tac_toe_nxn.sv
// Bench for tic_tac_toe_nxn: a 3x3 and a 4x4 (WIN_LEN 3) instance share one stimulus
// path; a cell-array game model predicts board, result, turn and illegal pulses.
module tb_tic_tac_toe_nxn;
    logic       clk = 1'b0;
    logic       reset;
    logic       play, pc;
    logic [3:0] ppos, cpos;
    bit         sel;

    always #5 clk = ~clk;

    tic_tac_toe_nxn_if #(.N(3)) bus3 ();
    tic_tac_toe_nxn_if #(.N(4)) bus4 ();

    assign bus3.play              = play & ~sel;
    assign bus3.pc                = pc & ~sel;
    assign bus3.player_position   = ppos;
    assign bus3.computer_position = cpos;
    assign bus4.play              = play & sel;
    assign bus4.pc                = pc & sel;
    assign bus4.player_position   = ppos;
    assign bus4.computer_position = cpos;

    tic_tac_toe_nxn #(.N(3), .WIN_LEN(3), .FIRST(0)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    tic_tac_toe_nxn #(.N(4), .WIN_LEN(3), .FIRST(0)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    logic [31:0] board_o;
    logic [1:0]  who_o;
    logic        turn_o, illegal_o;
    logic [4:0]  cnt_o;

    always_comb begin
        if (sel) begin
            board_o   = bus4.board;
            who_o     = bus4.who;
            turn_o    = bus4.turn;
            illegal_o = bus4.illegal;
            cnt_o     = bus4.move_count;
        end else begin
            board_o   = {14'd0, bus3.board};
            who_o     = bus3.who;
            turn_o    = bus3.turn;
            illegal_o = bus3.illegal;
            cnt_o     = {1'b0, bus3.move_count};
        end
    end

    // Game model: 0 empty, 1 player, 2 computer.
    int n, wl, cells;
    int cellv [25];
    int count, turn, done, who;
    int vectors, miscompares;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (dut N=%0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    function automatic logic [31:0] model_board();
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < cells; i++) b[2*i +: 2] = cellv[i][1:0];
        return b;
    endfunction

    function automatic bit model_win(input int side);
        int dr, dc, rr, cc;
        bit run;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                for (int d = 0; d < 4; d++) begin
                    dr  = (d == 0) ? 0 : 1;
                    dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                    run = 1'b1;
                    for (int k = 0; k < wl; k++) begin
                        rr = r + k * dr;
                        cc = c + k * dc;
                        if (rr < 0 || rr >= n || cc < 0 || cc >= n) run = 1'b0;
                        else if (cellv[rr*n + cc] != side) run = 1'b0;
                    end
                    if (run) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 25; i++) cellv[i] = 0;
        count = 0;
        turn  = 0;
        done  = 0;
        who   = 0;
    endtask

    task automatic model_step(input bit pe, input bit ce, input int pp, input int cp,
                              output bit exp_ill, output bit acc);
        bit holder_e, other_e;
        int pos;
        exp_ill = 1'b0;
        acc     = 1'b0;
        if (done != 0) begin
            exp_ill = pe | ce;
        end else begin
            holder_e = (turn != 0) ? ce : pe;
            other_e  = (turn != 0) ? pe : ce;
            pos      = (turn != 0) ? cp : pp;
            if (holder_e) begin
                if (pos < cells && cellv[pos] == 0) begin
                    cellv[pos] = turn + 1;
                    count++;
                    acc = 1'b1;
                end else begin
                    exp_ill = 1'b1;
                end
            end else if (other_e) begin
                exp_ill = 1'b1;
            end
        end
    endtask

    task automatic model_resolve();
        if (model_win(turn + 1)) begin
            who  = turn + 1;
            done = 1;
        end else if (count == cells) begin
            who  = 3;
            done = 1;
        end else begin
            turn = 1 - turn;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        play  = 1'b0;
        pc    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_board", board_o, 32'd0);
        chk("rst_who", 32'(who_o), 32'd0);
        chk("rst_turn", 32'(turn_o), 32'd0);
        chk("rst_count", 32'(cnt_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        reset = 1'b0;
    endtask

    task automatic select_dut(input bit s);
        sel   = s;
        n     = s ? 4 : 3;
        wl    = 3;
        cells = n * n;
        do_reset();
    endtask

    // One request: edge, accept/reject cycle, CHECK cycle, then held level and release.
    task automatic apply(input bit pe, input bit ce, input int pp, input int cp,
                         input int hold, input bit poke);
        bit exp_ill, acc;
        play = pe;
        pc   = ce;
        ppos = 4'(pp);
        cpos = 4'(cp);
        @(posedge clk);
        #1;
        model_step(pe, ce, pp, cp, exp_ill, acc);
        chk("illegal", 32'(illegal_o), 32'(exp_ill));
        chk("board", board_o, model_board());
        chk("count", 32'(cnt_o), 32'(count));
        if (acc && poke) begin
            play = 1'b1;
            pc   = 1'b1;
        end
        @(posedge clk);
        #1;
        if (acc) model_resolve();
        chk("who", 32'(who_o), 32'(who));
        chk("illegal_pulse", 32'(illegal_o), 32'd0);
        chk("board_after_check", board_o, model_board());
        if (done == 0) chk("turn", 32'(turn_o), 32'(turn));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("held_level", 32'(illegal_o), 32'd0);
        end
        play = 1'b0;
        pc   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic random_game();
        int extra;
        extra = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int r;
            bit pe, ce;
            r = int'($urandom_range(99, 0));
            if (r < 65)      {pe, ce} = (turn != 0) ? 2'b01 : 2'b10;
            else if (r < 85) {pe, ce} = 2'b11;
            else             {pe, ce} = (turn != 0) ? 2'b10 : 2'b01;
            apply(pe, ce, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
            if (done != 0) extra++;
            if (extra > 2) break;
        end
    endtask

    initial begin
        bit ei, acc;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        play  = 1'b0;
        pc    = 1'b0;
        ppos  = '0;
        cpos  = '0;

        // Computer takes the top row.
        select_dut(1'b0);
        apply(1, 0, 4, 0, 8, 0);
        apply(0, 1, 0, 0, 8, 0);
        apply(1, 0, 8, 0, 8, 0);
        apply(0, 1, 0, 1, 8, 0);
        apply(1, 0, 6, 0, 8, 0);
        apply(0, 1, 0, 2, 8, 0);
        chk("row_win_who", 32'(who_o), 32'd2);
        chk("row_win_cells", 32'(board_o[5:0]), 32'h2A);
        apply(1, 0, 3, 0, 0, 0);
        chk("done_request", 32'(who_o), 32'd2);

        // Occupied target for the computer.
        do_reset();
        apply(1, 0, 4, 0, 0, 0);
        apply(0, 1, 0, 4, 0, 0);
        chk("occupied_turn", 32'(turn_o), 32'd1);
        chk("occupied_cell", 32'(board_o[9:8]), 32'd1);

        // Held play level, then a second play edge out of turn.
        do_reset();
        apply(1, 0, 4, 0, 20, 0);
        apply(1, 0, 5, 0, 0, 0);
        chk("held_count", 32'(cnt_o), 32'd1);

        // Draw sequence.
        do_reset();
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 0);
        apply(1, 0, 2, 0, 0, 0);
        apply(0, 1, 0, 4, 0, 0);
        apply(1, 0, 3, 0, 0, 0);
        apply(0, 1, 0, 5, 0, 0);
        apply(1, 0, 7, 0, 0, 0);
        apply(0, 1, 0, 6, 0, 0);
        apply(1, 0, 8, 0, 0, 0);
        chk("draw_who", 32'(who_o), 32'd3);
        chk("draw_count", 32'(cnt_o), 32'd9);

        // Out-of-board target.
        do_reset();
        apply(1, 0, 12, 0, 0, 0);
        chk("oob_count", 32'(cnt_o), 32'd0);

        // Reset landing on the CHECK cycle of the third move, play held through it.
        do_reset();
        apply(1, 0, 4, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        play = 1'b1;
        ppos = 4'd8;
        @(posedge clk);
        #1;
        model_step(1'b1, 1'b0, 8, 0, ei, acc);
        chk("third_board", board_o, model_board());
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("chk_rst_board", board_o, 32'd0);
        chk("chk_rst_who", 32'(who_o), 32'd0);
        chk("chk_rst_turn", 32'(turn_o), 32'd0);
        chk("chk_rst_illegal", 32'(illegal_o), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("held_through_reset", 32'(illegal_o), 32'd0);
        chk("held_through_board", board_o, 32'd0);
        play = 1'b0;
        @(posedge clk);
        #1;

        // 4x4 board, WIN_LEN 3 diagonal 5-10-15.
        select_dut(1'b1);
        apply(1, 0, 5, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        apply(1, 0, 10, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 0);
        apply(1, 0, 15, 0, 0, 0);
        chk("diag4_who", 32'(who_o), 32'd1);

        select_dut(1'b0);
        repeat (25) random_game();
        select_dut(1'b1);
        repeat (25) random_game();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tic_tac_toe_nxn.md
TIC_TAC_TOE_NXN -- requirements
Module: tic_tac_toe_nxn

Interface
REQ-001 Parameter N, default 3: board side length; legal range 3..5.
REQ-002 Parameter WIN_LEN, default 3: consecutive marks needed to win; legal range 3..N.
REQ-003 Parameter FIRST, default 0: side that moves first after reset; 0 = player, 1 = computer.
REQ-004 Derived constants: CELLS = N*N; PW = clog2(CELLS); CW = clog2(CELLS+1).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 play  in  1  player move request (level); a move is taken on its 0->1 transition only.
REQ-008 pc  in  1  computer move request (level); a move is taken on its 0->1 transition only.
REQ-009 player_position  in  PW  target cell index for a player move; row-major, 0-based.
REQ-010 computer_position  in  PW  target cell index for a computer move; row-major, 0-based.
REQ-011 board  out  2*CELLS  cell i occupies bits [2i+1:2i]; 00 = empty, 01 = player, 10 = computer.
REQ-012 who  out  2  result code; 00 = none, 01 = player won, 10 = computer won, 11 = draw.
REQ-013 turn  out  1  side to move; 0 = player, 1 = computer. Valid only in state TURN.
REQ-014 illegal  out  1  one-cycle pulse marking a rejected request.
REQ-015 move_count  out  CW  number of marks currently on the board.

Function
REQ-016 Request edge detection uses registered copies of play and pc; a held level yields exactly one request.
REQ-017 FSM states: TURN, CHECK, DONE.
REQ-018 TURN, turn-holder's request edge, target < CELLS, target cell empty: write the mark; increment move_count; go to CHECK.
REQ-019 TURN, turn-holder's request with target >= CELLS or target cell occupied: board unchanged; illegal = 1 for one cycle; stay in TURN; turn unchanged.
REQ-020 TURN, request edge from the non-turn-holder alone: illegal = 1 for one cycle; board unchanged.
REQ-021 TURN, simultaneous play and pc edges: only the turn-holder's request is processed; the other is dropped with no illegal pulse.
REQ-022 CHECK lasts exactly one cycle and evaluates the updated board for the side that just moved:
  - win -> DONE, who = 01 or 10
  - no win and move_count == CELLS -> DONE, who = 11
  - otherwise -> TURN, turn toggled
REQ-023 Request edges arriving in CHECK are dropped: no board change, no illegal pulse.
REQ-024 Win condition: WIN_LEN consecutive same-side marks in any window of a row, a column, a main-direction diagonal, or an anti-direction diagonal, at every valid offset on the board.
REQ-025 Win takes priority over draw when the final move fills the board and completes a line.
REQ-026 Latency: board updates at the edge that accepts a move; who and the next turn become valid one cycle later.
REQ-027 DONE holds board and who until reset; any request edge in DONE gives illegal = 1 and changes nothing.
REQ-028 illegal is registered, never asserted in consecutive cycles for a single edge, and otherwise 0.

Reset
REQ-029 While reset = 1 at a clock edge:
  - board = 0, who = 00, move_count = 0, illegal = 0
  - turn = FIRST, state = TURN
  - edge-detect registers load the current play and pc, so a level held through reset is not a request
REQ-030 Reset overrides any in-progress move or CHECK evaluation from any state.

Verification
REQ-031 N=3, FIRST=0; moves player 4, pc 0, player 8, pc 1, player 6, pc 2, each as a 10-cycle pulse -> board cells 0,1,2 = 10; who = 10 one cycle after the last write; later requests give illegal.
REQ-032 N=3; player 4, then computer 4 -> illegal pulse; cell 4 stays 01; turn stays 1.
REQ-033 N=3; player 4 accepted, then play held high 20 cycles, then a second play edge before pc -> exactly one write; second edge gives illegal; move_count = 1.
REQ-034 N=3 sequence P0 C1 P2 C4 P3 C5 P7 C6 P8 -> who = 11, move_count = 9.
REQ-035 N=4, WIN_LEN=3; player 5, 10, 15 interleaved with computer 0, 1 -> who = 01 after cell 15; cell 0 unused in that line.
REQ-036 Reset asserted in CHECK after the 3rd move -> next cycle board = 0, who = 00, turn = FIRST, no illegal pulse.
